// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for a register bank: one grant per cycle, alternating priority.
// One-cycle latency from request to registered grant/enable/data; stall holds off new grants.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 req_a,
  input  logic [AW-1:0]        addr_a,
  input  logic [DW-1:0]        data_a,
  input  logic                 req_b,
  input  logic [AW-1:0]        addr_b,
  input  logic [DW-1:0]        data_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic [(2**AW)-1:0]   reg_en,
  output logic [DW-1:0]        reg_d
);

  localparam int NREG = 2**AW;

  logic            prio;
  logic            elig_a;
  logic            elig_b;
  logic            win_a;
  logic            win_b;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] win_en;

  // A requester still showing its grant is ineligible, so a held req is never granted twice.
  always_comb begin
    elig_a   = req_a & ~gnt_a & ~stall;
    elig_b   = req_b & ~gnt_b & ~stall;
    win_a    = elig_a & (~elig_b | ~prio);
    win_b    = elig_b & (~elig_a | prio);
    win_addr = win_b ? addr_b : addr_a;
    win_data = win_b ? data_b : data_a;
    win_en   = '0;
    if ((win_a | win_b) && (win_addr != '0)) begin
      win_en[win_addr] = 1'b1;
    end
  end

  // Register 0 is hardwired zero: its enable is never raised, but reg_d still loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      reg_en <= '0;
      reg_d  <= '0;
      prio   <= 1'b0;
    end else begin
      gnt_a  <= win_a;
      gnt_b  <= win_b;
      reg_en <= win_en;
      if (win_a | win_b) begin
        reg_d <= win_data;
      end
      if (win_a) begin
        prio <= 1'b1;
      end else if (win_b) begin
        prio <= 1'b0;
      end
    end
  end

endmodule
